// File: rtl/vidmem_axil_responder.sv
// AXI4-Lite responder over a byte-writable word RAM; one outstanding read and one outstanding write, SLVERR outside the RAM.
// Optional VIDMEM_PIXEL_PORT_EN adds a registered read-only scan-out port (PIX_ADDR/PIX_DATA).
module vidmem_axil_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 16,
   parameter int MEM_ADDR_BITS      = 10
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
`ifdef VIDMEM_PIXEL_PORT_EN
   input  logic [MEM_ADDR_BITS-1:0]        PIX_ADDR,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   PIX_DATA,
`endif
   output logic [7:0]                      ERR_CNT
);

   localparam int DEPTH = 2**MEM_ADDR_BITS;
   localparam int NB    = C_S_AXI_DATA_WIDTH/8;
   localparam int AW    = C_S_AXI_ADDR_WIDTH;

   typedef enum logic {W_COLLECT, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_RESP} rstate_t;

   wstate_t wstate, wstate_next;
   rstate_t rstate, rstate_next;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

   logic                          aw_held, w_held;
   logic [AW-1:0]                 aw_addr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
   logic [NB-1:0]                 w_strb_q;
   logic                          aw_rdy, w_rdy, aw_hs, w_hs, commit;
   logic                          bvalid, rvalid, ar_rdy, ar_hs;
   logic [1:0]                    bresp, rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
   logic [7:0]                    err_cnt;
   logic [1:0]                    err_inc;
   logic [8:0]                    err_sum;

   logic [AW-1:0]                 wr_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic [NB-1:0]                 wr_strb;
   logic [MEM_ADDR_BITS-1:0]      wr_idx, rd_idx;
   logic                          w_oor, r_oor;
   logic                          unused_ok;

   // The committing beat may come straight off the bus or from the holding registers.
   assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
   assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
   assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
   assign wr_idx  = wr_addr[MEM_ADDR_BITS+1:2];
   assign rd_idx  = S_AXI_ARADDR[MEM_ADDR_BITS+1:2];

   generate
      if (MEM_ADDR_BITS + 2 < AW) begin : g_range
         assign w_oor = |wr_addr[AW-1:MEM_ADDR_BITS+2];
         assign r_oor = |S_AXI_ARADDR[AW-1:MEM_ADDR_BITS+2];
      end else begin : g_full
         assign w_oor = 1'b0;
         assign r_oor = 1'b0;
      end
   endgenerate

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

   always_ff @(posedge ACLK) begin
      if (ARESET) wstate <= W_COLLECT;
      else        wstate <= wstate_next;
   end

   always_comb begin
      wstate_next = wstate;
      aw_rdy      = 1'b0;
      w_rdy       = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      commit      = 1'b0;
      if (!ARESET) begin
         case (wstate)
            W_COLLECT: begin
               aw_rdy = !aw_held;
               w_rdy  = !w_held;
               aw_hs  = S_AXI_AWVALID && aw_rdy;
               w_hs   = S_AXI_WVALID && w_rdy;
               if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                  commit      = 1'b1;
                  wstate_next = W_RESP;
               end
            end
            W_RESP: if (S_AXI_BREADY) wstate_next = W_COLLECT;
            default: wstate_next = W_COLLECT;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= S_AXI_AWADDR;
            aw_held   <= 1'b1;
         end
         if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
            w_held   <= 1'b1;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= w_oor ? 2'b10 : 2'b00;
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (commit && !w_oor) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) rstate <= R_IDLE;
      else        rstate <= rstate_next;
   end

   always_comb begin
      rstate_next = rstate;
      ar_rdy      = 1'b0;
      if (!ARESET) begin
         case (rstate)
            R_IDLE: begin
               ar_rdy = 1'b1;
               if (S_AXI_ARVALID) rstate_next = R_RESP;
            end
            R_RESP: if (S_AXI_RREADY) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
         endcase
      end
   end

   assign ar_hs = S_AXI_ARVALID && ar_rdy;

   // Reading mem with the same edge that writes it yields the pre-write word.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid <= 1'b0;
         rresp  <= 2'b00;
         rdata  <= '0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rresp  <= r_oor ? 2'b10 : 2'b00;
         rdata  <= r_oor ? '0 : mem[rd_idx];
      end else if (rvalid && S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

   assign err_inc = {1'b0, commit && w_oor} + {1'b0, ar_hs && r_oor};
   assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

   always_ff @(posedge ACLK) begin
      if (ARESET)                err_cnt <= 8'd0;
      else if (err_sum > 9'd255) err_cnt <= 8'd255;
      else                       err_cnt <= err_sum[7:0];
   end

`ifdef VIDMEM_PIXEL_PORT_EN
   always_ff @(posedge ACLK) begin
      if (ARESET) PIX_DATA <= '0;
      else        PIX_DATA <= mem[PIX_ADDR];
   end
`endif

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = w_rdy;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RRESP   = rresp;
   assign S_AXI_RDATA   = rdata;
   assign ERR_CNT       = err_cnt;

endmodule

// File: tb/tb_vidmem_axil_responder.sv
// Directed bench for vidmem_axil_responder; inputs driven and outputs sampled on the falling edge.
module tb_vidmem_axil_responder;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic [15:0] awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rvalid, rready = 0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;
   logic [7:0]  err_cnt;
`ifdef VIDMEM_PIXEL_PORT_EN
   logic [9:0]  pix_addr = '0;
   logic [31:0] pix_data;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vidmem_axil_responder dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
`ifdef VIDMEM_PIXEL_PORT_EN
      .PIX_ADDR(pix_addr), .PIX_DATA(pix_data),
`endif
      .ERR_CNT(err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, ah, wh;
      int t = 0;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1; wvalid = 1;
      while (!(aw_done && w_done) && t < 20) begin
         ah = awvalid && awready;
         wh = wvalid && wready;
         @(negedge clk); t++;
         if (ah) begin awvalid = 0; aw_done = 1; end
         if (wh) begin wvalid = 0; w_done = 1; end
      end
      awvalid = 0; wvalid = 0;
      t = 0;
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      check("bvalid_wait", bvalid, 1);
      resp = bresp;
      bready = 1;
      @(negedge clk);
      bready = 0;
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
      int t = 0;
      araddr = a; arvalid = 1;
      while (!arready && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      arvalid = 0;
      check("rvalid_lat1", rvalid, 1);
      d = rdata; resp = rresp;
      rready = 1;
      @(negedge clk);
      rready = 0;
   endtask

   logic [1:0]  resp;
   logic [31:0] d;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      areset = 0;
      @(negedge clk);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_errcnt", err_cnt, 0);
      check("idle_awready", awready, 1);

      // 1: basic write/read-back
      for (int i = 0; i < 4; i++) begin
         axi_write(16'(4*i), 32'(i+1), 4'hF, resp);
         check("t1_bresp", resp, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(16'(4*i), d, resp);
         check("t1_rdata", d, 32'(i+1));
         check("t1_rresp", resp, 2'b00);
      end
      check("t1_errcnt", err_cnt, 0);

      // 2: AW three cycles ahead of W
      awaddr = 16'h10; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      check("t2_awready_n", awready, 1);
      @(negedge clk); awvalid = 0;
      check("t2_awready_n1", awready, 0);
      @(negedge clk);
      check("t2_bvalid_early", bvalid, 0);
      @(negedge clk); wvalid = 1;
      check("t2_wready", wready, 1);
      @(negedge clk); wvalid = 0;
      check("t2_bvalid", bvalid, 1);
      check("t2_bresp", bresp, 2'b00);
      bready = 1; @(negedge clk); bready = 0;
      check("t2_bdone", bvalid, 0);
      // W ahead of AW
      wdata = 32'hCAFEF00D; wvalid = 1;
      @(negedge clk); wvalid = 0;
      check("t2b_wready", wready, 0);
      check("t2b_bvalid_early", bvalid, 0);
      repeat (2) @(negedge clk);
      awaddr = 16'h14; awvalid = 1;
      @(negedge clk); awvalid = 0;
      check("t2b_bvalid", bvalid, 1);
      bready = 1; @(negedge clk); bready = 0;
      axi_read(16'h10, d, resp);
      check("t2_rd10", d, 32'hDEADBEEF);
      axi_read(16'h14, d, resp);
      check("t2_rd14", d, 32'hCAFEF00D);

      // 3: byte strobes, including an empty strobe
      axi_write(16'h20, 32'hAABBCCDD, 4'hF, resp);
      axi_write(16'h20, 32'h00001122, 4'h3, resp);
      axi_read(16'h20, d, resp);
      check("t3_strb", d, 32'hAABB1122);
      axi_write(16'h22, 32'h0, 4'h0, resp);
      check("t3_strb0_resp", resp, 2'b00);
      axi_read(16'h20, d, resp);
      check("t3_strb0", d, 32'hAABB1122);

      // 4: out of range
      axi_write(16'h1000, 32'hFFFFFFFF, 4'hF, resp);
      check("t4_bresp", resp, 2'b10);
      axi_read(16'h1000, d, resp);
      check("t4_rresp", resp, 2'b10);
      check("t4_rdata", d, 0);
      check("t4_errcnt", err_cnt, 2);
      axi_read(16'h0, d, resp);
      check("t4_word0", d, 1);

      // 5: stalled responses, then reset mid-stall
      awaddr = 16'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 16'h4; arvalid = 1;
      @(negedge clk); awvalid = 0; wvalid = 0; arvalid = 0;
      for (int i = 0; i < 5; i++) begin
         check("t5_bvalid", bvalid, 1);
         check("t5_rvalid", rvalid, 1);
         check("t5_rdata", rdata, 2);
         check("t5_rresp", rresp, 2'b00);
         check("t5_arready", arready, 0);
         check("t5_awready", awready, 0);
         @(negedge clk);
      end
      areset = 1; #1;
      check("t5_rst_awready", awready, 0);
      @(negedge clk); areset = 0;
      check("t5_rst_bvalid", bvalid, 0);
      check("t5_rst_rvalid", rvalid, 0);
      check("t5_rst_errcnt", err_cnt, 0);

      // saturating error count
      for (int i = 0; i < 260; i++) axi_read(16'hF000, d, resp);
      check("sat_errcnt", err_cnt, 255);

`ifdef VIDMEM_PIXEL_PORT_EN
      // 6: pixel port
      axi_write(16'h14, 32'h12345678, 4'hF, resp);
      pix_addr = 10'd5;
      @(negedge clk);
      check("t6_pix", pix_data, 32'h12345678);
      awaddr = 16'h14; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(negedge clk); awvalid = 0; wvalid = 0;
      check("t6_pix_old", pix_data, 32'h12345678);
      @(negedge clk);
      check("t6_pix_new", pix_data, 32'h0);
      bready = 1; @(negedge clk); bready = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vidmem_axil_responder.md
Name: vidmem_axil_responder

Overview:
- AXI4-Lite slave (responder) backed by a word-addressed block RAM.
- Serves as the far end of the manager's M00_AXI/M01_AXI initiator ports, both in the bus-functional example design and as the video memory the VGA path reads.
- Accepts single-beat writes with byte strobes and single-beat reads, one outstanding transaction of each kind.
- Flags out-of-range accesses with SLVERR and keeps a saturating error count.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 16, byte address width.
- MEM_ADDR_BITS, 10, word-index width; memory depth DEPTH = 2**MEM_ADDR_BITS words. Must satisfy MEM_ADDR_BITS+2 <= C_S_AXI_ADDR_WIDTH.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- ERR_CNT  out  8  saturating count of SLVERR responses issued.

Behaviour:
Address decode:
- Word index = addr[MEM_ADDR_BITS+1:2]; addr[1:0] ignored.
- addr[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_BITS+2] nonzero means out of range.

Reset (ARESET high at a rising edge):
- BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, ERR_CNT=0.
- aw_held and w_held cleared; AWREADY/WREADY/ARREADY forced 0 while ARESET is high.
- Memory contents are not reset.
- Reset mid-transaction aborts any held AW/W and any pending B/R response with no memory update.

Write channel (states W_COLLECT, W_RESP):
- W_COLLECT: AWREADY = !aw_held; WREADY = !w_held. AW and W are accepted independently in either order or in the same cycle; address and data/strobe are latched.
- Commit happens on the edge where both are available (held or handshaking that cycle). In-range: each byte i with WSTRB[i]=1 is written. Out-of-range: no write, BRESP=10.
- After commit: BVALID=1 at the next edge, state W_RESP, AWREADY=WREADY=0.
- W_RESP: BVALID and BRESP held until BVALID&&BREADY, then return to W_COLLECT with held flags cleared. Back-to-back writes therefore have a 1-cycle minimum gap after the B handshake.
- WSTRB=0000 in range is an OKAY response with no memory change.

Read channel (states R_IDLE, R_RESP):
- R_IDLE: ARREADY=1.
- On AR handshake: RVALID=1 at the next edge (latency 1), RDATA = mem[index] for in range, RDATA=0 with RRESP=10 for out of range; state R_RESP, ARREADY=0.
- R_RESP: RDATA/RRESP stable until RVALID&&RREADY, then R_IDLE.
- Read and write commit to the same word in the same cycle: read returns the old data (read-before-write).

ERR_CNT:
- Increments by 1 per BVALID or RVALID assertion carrying SLVERR.
- Same-cycle B and R errors add 2.
- Saturates at 255, no wrap.

Channel independence:
- Read and write channels are fully independent; neither blocks the other.

Optional Feature:
Macro VIDMEM_PIXEL_PORT_EN.
- Defined: adds ports PIX_ADDR in MEM_ADDR_BITS and PIX_DATA out 32, a second read-only RAM port for the VGA scan-out.
  - PIX_DATA = mem[PIX_ADDR] registered with 1-cycle latency.
  - Reset clears PIX_DATA to 0.
  - A same-cycle write to the same word returns the old data.
  - No interaction with AXI handshakes.
- Undefined: the ports do not exist and the RAM is inferred single-read-port.

Test Plan:
1. Write 0x00000001..0x00000004 to 0x0,0x4,0x8,0xC (WSTRB=F), then read back -> BRESP=00 each, RDATA 1,2,3,4, RRESP=00, ERR_CNT=0.
2. AW at cycle n, W at n+3 to 0x10 with 0xDEADBEEF -> AWREADY low from n+1, BVALID rises exactly 1 cycle after the W handshake. Repeat with W before AW: same result.
3. Write 0xAABBCCDD to 0x20, then 0x00001122 with WSTRB=0011 -> read 0x20 returns 0xAABB1122.
4. Write and read at address 0x1000 (MEM_ADDR_BITS=10) -> BRESP=10, RRESP=10, RDATA=0, ERR_CNT=2; memory word 0 unchanged.
5. Hold BREADY/RREADY low 5 cycles -> BVALID, RVALID, RDATA, RRESP stable throughout, ARREADY/AWREADY low. Assert ARESET for 1 cycle mid-stall -> BVALID=RVALID=0 next cycle, ERR_CNT=0.
6. With VIDMEM_PIXEL_PORT_EN defined: write 0x12345678 to word 5, set PIX_ADDR=5 -> PIX_DATA=0x12345678 one cycle later. Same-cycle AXI write of 0x0 to word 5 -> old value returned that cycle, new value the next.
